// File: rtl/rgb_led_bargraph_frame_writer_pkg.sv
// Shared constants and types for the bargraph frame writer.
// State codes, command bytes and the dimming clamp helper.
package rgb_led_bargraph_pkg;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] PIXELS   = 3'd1;
    localparam logic [2:0] LEVEL_HI = 3'd2;
    localparam logic [2:0] LEVEL_LO = 3'd3;
    localparam logic [2:0] SWAP     = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE     = IDLE,
        ST_PIXELS   = PIXELS,
        ST_LEVEL_HI = LEVEL_HI,
        ST_LEVEL_LO = LEVEL_LO,
        ST_SWAP     = SWAP
    } state_t;

    localparam logic [7:0] CMD_FRAME = 8'h01;
    localparam logic [7:0] CMD_LEVEL = 8'h02;

    localparam logic [8:0] LEVEL_MAX        = 9'd256;
    localparam int         PIXELS_PER_FRAME = 256;

    function automatic logic [8:0] clamp_level(input logic [15:0] v);
        return (v > 16'(LEVEL_MAX)) ? LEVEL_MAX : v[8:0];
    endfunction

endpackage

// File: rtl/rgb_led_bargraph_frame_writer_if.sv
// Framed byte stream with valid/ready flow control.
// The host side is the master, the frame writer is the slave.
interface rgb_led_bargraph_frame_writer_if;

    logic [7:0] in_data;
    logic       in_sof;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output in_data,
        output in_sof,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_sof,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/rgb_led_bargraph_frame_writer.sv
// Loads pixel bytes into the back buffer, requests a buffer swap per
// frame and carries global-dimming level updates.
module rgb_led_bargraph_frame_writer #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                                clk,
    input  logic                                rst_n,
    rgb_led_bargraph_frame_writer_if.slave      stream,
    input  logic                                buffer_current,
    output logic                                buffer_select,
    output logic                                wr,
    output logic [8:0]                          wr_addr,
    output logic [7:0]                          wr_data,
    output logic [8:0]                          level,
    output logic                                frame_done,
    output logic                                frame_abort
);

    import rgb_led_bargraph_pkg::*;

    localparam logic [15:0] TIMEOUT_LOAD = 16'(TIMEOUT_CYCLES);
    localparam logic [7:0]  LAST_INDEX   = 8'(PIXELS_PER_FRAME - 1);

    state_t      state_q, state_d;
    logic [7:0]  index_q, index_d;
    logic [15:0] timer_q, timer_d;
    logic [7:0]  level_hi_q, level_hi_d;
    logic        select_d;
    logic        wr_d;
    logic [8:0]  wr_addr_d;
    logic [7:0]  wr_data_d;
    logic [8:0]  level_d;
    logic        done_d;
    logic        abort_d;
    logic        accept;
    logic        command;

    assign stream.in_ready = (state_q != ST_SWAP);
    assign accept          = stream.in_valid & stream.in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            index_q       <= '0;
            timer_q       <= '0;
            level_hi_q    <= '0;
            buffer_select <= 1'b0;
            wr            <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            level         <= LEVEL_MAX;
            frame_done    <= 1'b0;
            frame_abort   <= 1'b0;
        end else begin
            state_q       <= state_d;
            index_q       <= index_d;
            timer_q       <= timer_d;
            level_hi_q    <= level_hi_d;
            buffer_select <= select_d;
            wr            <= wr_d;
            wr_addr       <= wr_addr_d;
            wr_data       <= wr_data_d;
            level         <= level_d;
            frame_done    <= done_d;
            frame_abort   <= abort_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        timer_d    = timer_q;
        level_hi_d = level_hi_q;
        select_d   = buffer_select;
        wr_d       = 1'b0;
        wr_addr_d  = wr_addr;
        wr_data_d  = wr_data;
        level_d    = level;
        done_d     = 1'b0;
        abort_d    = 1'b0;
        command    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                command = accept;
            end
            ST_PIXELS: begin
                if (accept && stream.in_sof) begin
                    abort_d = 1'b1;
                    command = 1'b1;
                end else if (accept) begin
                    wr_d      = 1'b1;
                    wr_addr_d = {~buffer_select, index_q};
                    wr_data_d = stream.in_data;
                    index_d   = index_q + 8'd1;
                    timer_d   = TIMEOUT_LOAD;
                    if (index_q == LAST_INDEX) begin
                        state_d  = ST_SWAP;
                        select_d = ~buffer_select;
                    end
                end else if (timer_q <= 16'd1) begin
                    // the idle budget is spent on this cycle
                    abort_d = 1'b1;
                    timer_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            ST_LEVEL_HI: begin
                if (accept && stream.in_sof) begin
                    command = 1'b1;
                end else if (accept) begin
                    level_hi_d = stream.in_data;
                    state_d    = ST_LEVEL_LO;
                end
            end
            ST_LEVEL_LO: begin
                if (accept && stream.in_sof) begin
                    command = 1'b1;
                end else if (accept) begin
                    level_d = clamp_level({level_hi_q, stream.in_data});
                    state_d = ST_IDLE;
                end
            end
            ST_SWAP: begin
                if (buffer_current == buffer_select) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // an interrupting start byte is decoded as a fresh command
        if (command) begin
            state_d = ST_IDLE;
            if (stream.in_sof && stream.in_data == CMD_FRAME) begin
                state_d = ST_PIXELS;
                index_d = '0;
                timer_d = TIMEOUT_LOAD;
            end else if (stream.in_sof && stream.in_data == CMD_LEVEL) begin
                state_d = ST_LEVEL_HI;
            end
        end
    end

endmodule

// File: tb/tb_rgb_led_bargraph_frame_writer.sv
// Self-checking bench: directed frame/level/timeout/reset sequences,
// a level vector table and randomized messages against a reference model.
module tb_rgb_led_bargraph_frame_writer;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       buffer_current;
    logic       buffer_select;
    logic       wr;
    logic [8:0] wr_addr;
    logic [7:0] wr_data;
    logic [8:0] level;
    logic       frame_done;
    logic       frame_abort;

    rgb_led_bargraph_frame_writer_if stream_if();

    rgb_led_bargraph_frame_writer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stream         (stream_if),
        .buffer_current (buffer_current),
        .buffer_select  (buffer_select),
        .wr             (wr),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .level          (level),
        .frame_done     (frame_done),
        .frame_abort    (frame_abort)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    logic [16:0] wq[$];
    logic [7:0]  mem[512];
    logic [7:0]  frame_bytes[256];
    int          wr_total  = 0;
    int          bad_bank  = 0;
    int          done_cnt  = 0;
    int          abort_cnt = 0;
    int          drv_delay = 500;
    int          drv_cnt   = 0;

    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
        logic [8:0] lvl;
    } lvl_vec_t;

    lvl_vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic sof);
        int   n;
        logic acc;
        n = 0;
        acc = 1'b0;
        stream_if.in_data  = d;
        stream_if.in_sof   = sof;
        stream_if.in_valid = 1'b1;
        while (!acc && n < 3000) begin
            acc = stream_if.in_ready;
            step();
            n++;
        end
        if (!acc) check("send_bound", 32'(acc), 32'd1);
        stream_if.in_valid = 1'b0;
    endtask

    task automatic send_frame(input bit with_cmd, input int gapmax);
        wq.delete();
        if (with_cmd) send(8'h01, 1'b1);
        for (int i = 0; i < 256; i++) begin
            repeat ($urandom_range(0, gapmax)) step();
            send(frame_bytes[i], 1'b0);
        end
    endtask

    task automatic check_writes(input string name, input logic bank,
                                input int count);
        int bad;
        bad = 0;
        if (wq.size() != count) bad++;
        else
            for (int i = 0; i < count; i++)
                if (wq[i] != {bank, 8'(i), frame_bytes[i]}) bad++;
        check(name, 32'(bad), 32'd0);
    endtask

    task automatic wait_done(input string name);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < 5000) begin
            step();
            n++;
        end
        check(name, 32'(done_cnt - start), 32'd1);
    endtask

    // observer: RAM image, write log and pulse counters
    always @(negedge clk) begin
        if (wr) begin
            wq.push_back({wr_addr, wr_data});
            mem[wr_addr] = wr_data;
            wr_total++;
            if (wr_addr[8] == buffer_current) bad_bank++;
        end
        if (frame_done) done_cnt++;
        if (frame_abort) abort_cnt++;
    end

    // display driver model: follows buffer_select after drv_delay cycles
    initial begin
        buffer_current = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                buffer_current = 1'b0;
                drv_cnt = 0;
            end else if (buffer_select != buffer_current) begin
                drv_cnt++;
                if (drv_cnt >= drv_delay) begin
                    buffer_current = buffer_select;
                    drv_cnt = 0;
                end
            end
        end
    end

    initial begin
        int n, a0, w0, d0;
        logic exp_sel;
        int exp_level;
        int v;

        tbl[0] = '{8'h00, 8'h80, 9'd128};
        tbl[1] = '{8'h01, 8'h2C, 9'd256};
        tbl[2] = '{8'h01, 8'h00, 9'd256};
        tbl[3] = '{8'h01, 8'h01, 9'd256};
        tbl[4] = '{8'h00, 8'h00, 9'd0};
        tbl[5] = '{8'h00, 8'hFF, 9'd255};
        tbl[6] = '{8'hFF, 8'hFF, 9'd256};
        tbl[7] = '{8'h00, 8'h01, 9'd1};
        tbl[8] = '{8'h00, 8'h40, 9'd64};

        rst_n = 1'b0;
        stream_if.in_valid = 1'b0;
        stream_if.in_sof   = 1'b0;
        stream_if.in_data  = 8'h00;
        repeat (3) step();
        check("rst_select", 32'(buffer_select), 32'd0);
        check("rst_wr", 32'(wr), 32'd0);
        check("rst_addr", 32'(wr_addr), 32'd0);
        check("rst_data", 32'(wr_data), 32'd0);
        check("rst_level", 32'(level), 32'd256);
        check("rst_pulses", 32'({frame_done, frame_abort}), 32'd0);
        check("rst_ready", 32'(stream_if.in_ready), 32'd1);
        rst_n = 1'b1;
        step();

        // frame 1: bytes equal their index, into bank 1
        for (int i = 0; i < 256; i++) frame_bytes[i] = 8'(i);
        drv_delay = 500;
        d0 = done_cnt;
        send_frame(1'b1, 0);
        check("f1_select", 32'(buffer_select), 32'd1);
        check("f1_swap_ready", 32'(stream_if.in_ready), 32'd0);
        n = 0;
        while (buffer_current != 1'b1 && n < 2000) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("f1_drv_flip", 32'(buffer_current), 32'd1);
        check("f1_no_early_done", 32'(done_cnt - d0), 32'd0);
        check("f1_wait_long", 32'(n >= 490), 32'd1);
        @(posedge clk);
        #1;
        check("f1_done_pulse", 32'(frame_done), 32'd1);
        check("f1_ready_back", 32'(stream_if.in_ready), 32'd1);
        check_writes("f1_writes", 1'b1, 256);
        step();
        check("f1_done_one_cycle", 32'(frame_done), 32'd0);

        // frame 2 into bank 0, frame 3 held off by SWAP with valid high
        drv_delay = 20;
        for (int i = 0; i < 256; i++) frame_bytes[i] = 8'(255 - i);
        d0 = done_cnt;
        send_frame(1'b1, 0);
        send(8'h01, 1'b1);
        check("f2_done_before_cmd", 32'(done_cnt - d0), 32'd1);
        check("f2_select", 32'(buffer_select), 32'd0);
        check_writes("f2_writes", 1'b0, 256);
        for (int i = 0; i < 256; i++) frame_bytes[i] = 8'(i) ^ 8'h5A;
        send_frame(1'b0, 1);
        wait_done("f3_done");
        check_writes("f3_writes", 1'b1, 256);
        check("f3_select", 32'(buffer_select), 32'd1);

        // level vectors
        for (int k = 0; k < 9; k++) begin
            send(8'h02, 1'b1);
            send(tbl[k].hi, 1'b0);
            send(tbl[k].lo, 1'b0);
            check($sformatf("level_vec%0d", k), 32'(level), 32'(tbl[k].lvl));
        end

        // level update cut short by a frame command
        a0 = abort_cnt;
        wq.delete();
        send(8'h02, 1'b1);
        send(8'hFF, 1'b0);
        send(8'h01, 1'b1);
        step();
        check("lvl_abort_level", 32'(level), 32'd64);
        check("lvl_abort_no_pulse", 32'(abort_cnt - a0), 32'd0);
        for (int i = 0; i < 256; i++) frame_bytes[i] = 8'(i * 3);
        for (int i = 0; i < 100; i++) send(frame_bytes[i], 1'b0);

        // idle timeout after 100 pixels
        a0 = abort_cnt;
        repeat (TO - 1) step();
        check("to_not_early", 32'(frame_abort), 32'd0);
        check("to_not_early_cnt", 32'(abort_cnt - a0), 32'd0);
        step();
        check("to_abort_pulse", 32'(frame_abort), 32'd1);
        check("to_select_kept", 32'(buffer_select), 32'd1);
        step();
        check("to_abort_one_cycle", 32'(frame_abort), 32'd0);
        check_writes("to_writes", 1'b0, 100);

        // restart at index 0, then abort with an in_sof byte
        wq.delete();
        send(8'h01, 1'b1);
        send(8'hAB, 1'b0);
        step();
        step();
        check("restart_count", 32'(wq.size()), 32'd1);
        if (wq.size() > 0)
            check("restart_addr", 32'(wq[0]), 32'({1'b0, 8'h00, 8'hAB}));
        a0 = abort_cnt;
        send(8'h7E, 1'b1);
        step();
        step();
        check("sof_abort", 32'(abort_cnt - a0), 32'd1);

        // junk in IDLE is dropped
        w0 = wr_total;
        d0 = done_cnt;
        send(8'h33, 1'b0);
        send(8'h01, 1'b0);
        send(8'h7E, 1'b1);
        send(8'h02, 1'b0);
        repeat (3) step();
        check("junk_no_writes", 32'(wr_total - w0), 32'd0);
        check("junk_ready", 32'(stream_if.in_ready), 32'd1);
        send(8'h02, 1'b1);
        send(8'h00, 1'b0);
        send(8'h20, 1'b0);
        check("junk_then_level", 32'(level), 32'd32);
        check("junk_no_done", 32'(done_cnt - d0), 32'd0);

        // reset while pixel 50 is offered
        wq.delete();
        send(8'h01, 1'b1);
        for (int i = 0; i < 50; i++) send(frame_bytes[i], 1'b0);
        stream_if.in_data  = 8'd50;
        stream_if.in_sof   = 1'b0;
        stream_if.in_valid = 1'b1;
        rst_n = 1'b0;
        step();
        check("mid_rst_wr", 32'(wr), 32'd0);
        check("mid_rst_level", 32'(level), 32'd256);
        check("mid_rst_select", 32'(buffer_select), 32'd0);
        stream_if.in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (2) step();
        check("mid_rst_writes", 32'(wq.size()), 32'd50);

        // randomized messages against the reference model
        exp_sel = 1'b0;
        exp_level = 256;
        for (int t = 0; t < 14; t++) begin
            case ($urandom_range(0, 2))
                0: begin
                    drv_delay = $urandom_range(2, 60);
                    for (int i = 0; i < 256; i++)
                        frame_bytes[i] = 8'($urandom);
                    send_frame(1'b1, 2);
                    wait_done($sformatf("rnd%0d_done", t));
                    exp_sel = ~exp_sel;
                    check($sformatf("rnd%0d_select", t),
                          32'(buffer_select), 32'(exp_sel));
                    n = 0;
                    for (int i = 0; i < 256; i++)
                        if (mem[{exp_sel, 8'(i)}] !== frame_bytes[i]) n++;
                    check($sformatf("rnd%0d_image", t), 32'(n), 32'd0);
                end
                1: begin
                    v = ($urandom_range(0, 1) == 0) ?
                        $urandom_range(0, 300) : int'($urandom & 32'hFFFF);
                    exp_level = (v > 256) ? 256 : v;
                    send(8'h02, 1'b1);
                    send(8'(v >> 8), 1'b0);
                    send(8'(v), 1'b0);
                    check($sformatf("rnd%0d_level", t),
                          32'(level), 32'(exp_level));
                end
                default: begin
                    w0 = wr_total;
                    v = $urandom_range(3, 255);
                    send(8'(v), 1'(($urandom_range(0, 1))));
                    repeat (2) step();
                    check($sformatf("rnd%0d_junk", t),
                          32'(wr_total - w0), 32'd0);
                    check($sformatf("rnd%0d_junk_level", t),
                          32'(level), 32'(exp_level));
                end
            endcase
        end
        check("bank_never_displayed", 32'(bad_bank), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rgb_led_bargraph_frame_writer.md
Name: rgb_led_bargraph_frame_writer

Overview:
Host-side loader that fills the bargraph frame buffer (2 buffers × 16 rows × 16 columns × 8 bit). It accepts a framed byte stream with valid/ready flow control and writes pixel bytes into the back buffer through the dual-port RAM write port. On a complete frame it requests a buffer swap and stalls until the display driver reports the swap. It also carries global-dimming `level` updates. Sits between the host interface logic and the display driver, sharing the driver's `clk`; the RAM write clock is tied to `clk`.

Parameters:
TIMEOUT_CYCLES, 65535, idle cycles allowed between pixel bytes before a frame load is aborted (16-bit counter; must be ≥ 1).

Ports:
clk  input  1  system clock; also drives the RAM write port clock
rst_n  input  1  synchronous active-low reset
in_data  input  8  stream byte
in_sof  input  1  marks a command byte (start of message)
in_valid  input  1  byte present
in_ready  output  1  block can accept; byte transfers when in_valid & in_ready
buffer_current  input  1  buffer currently displayed by the driver
buffer_select  output  1  buffer requested for display
wr  output  1  RAM write enable
wr_addr  output  9  {buffer, row[3:0], col[3:0]}
wr_data  output  8  pixel value
level  output  9  global dimming, 0..256
frame_done  output  1  one-cycle pulse when a swap completes
frame_abort  output  1  one-cycle pulse when a frame load is discarded

Behaviour:
- Reset values (rst_n low at a clk edge): state IDLE, buffer_select 0, wr 0, wr_addr 0, wr_data 0, level 256, frame_done 0, frame_abort 0, pixel index 0, timeout counter 0.
- in_ready is combinational from state:
  - 1 in IDLE, PIXELS, LEVEL_HI and LEVEL_LO.
  - 0 in SWAP.
- Accept = in_valid & in_ready.
- IDLE:
  - Accepted byte with in_sof=1 and data 0x01 → PIXELS; index cleared, timeout counter loaded.
  - Data 0x02 → LEVEL_HI.
  - Any other byte, including in_sof=0, is dropped; stay in IDLE.
- PIXELS:
  - On accept with in_sof=0, register a write on the next cycle: wr=1 for one cycle, wr_addr={~buffer_select, index}, wr_data=in_data. Index 0..255 maps to row=index[7:4], col=index[3:0].
  - Index increments per accepted byte. The accept at index 255 → SWAP.
  - On accept with in_sof=1, frame_abort pulses, the frame is discarded (no swap) and the byte is reprocessed as an IDLE command in the same cycle. Already-written back-buffer bytes remain; they are harmless.
  - Timeout counter reloads on every accept and decrements otherwise. At 0: frame_abort pulse → IDLE.
- SWAP:
  - On entry cycle, buffer_select toggles.
  - Stay in SWAP until buffer_current == buffer_select. The driver flips only after row 15 bit 7, so the wait can be up to one full frame.
  - Then pulse frame_done → IDLE.
  - No timeout in SWAP.
- LEVEL_HI / LEVEL_LO:
  - Two accepted bytes, high then low, form a 16-bit value v.
  - On the LEVEL_LO accept, level ← (v > 256) ? 256 : v[8:0], effective next cycle → IDLE.
  - An in_sof=1 byte in either state aborts the level update (level unchanged; frame_abort does not pulse) and is reprocessed as a command.
- wr is only ever asserted for the non-displayed buffer (~buffer_select). During SWAP no writes occur.
- Write latency: 1 cycle from accept to wr. Throughput: 1 byte/cycle in PIXELS. A 256-byte frame loads in 256 accepted cycles.
- Reset mid-load or mid-swap: everything returns to reset values immediately; a pending wr is suppressed. buffer_select returns to 0, matching the driver's reset.

Decomposition:
- Package rgb_led_bargraph_pkg holds:
  - state encoding localparams IDLE=0, PIXELS=1, LEVEL_HI=2, LEVEL_LO=3, SWAP=4;
  - CMD_FRAME=8'h01, CMD_LEVEL=8'h02;
  - LEVEL_MAX=9'd256, PIXELS_PER_FRAME=256.
- No sub-module. The timeout counter and the level clamp are inline.

Test Plan:
- Reset, then CMD 0x01 + bytes 0..255 with buffer_current=0 → 256 writes, wr_addr 0x100..0x1FF, wr_data == index. buffer_select goes to 1 and in_ready=0; a driver model sets buffer_current=1 after 500 cycles → frame_done pulse one cycle later, in_ready=1.
- Two back-to-back frames → second frame writes 0x000..0x0FF and buffer_select returns to 0. in_valid held high during SWAP → no byte consumed.
- CMD 0x02 + 0x00,0x80 → level=128. CMD 0x02 + 0x01,0x2C (300) → level=256. CMD 0x02 + 0xFF only, then an in_sof byte 0x01 → level unchanged and a frame load starts.
- CMD 0x01 + 100 pixels, then TIMEOUT_CYCLES=16 idle cycles → frame_abort pulse, buffer_select unchanged, next in_sof 0x01 restarts at index 0.
- Bytes with in_sof=0, and an in_sof=1 byte 0x7E, in IDLE → no writes, state stays IDLE. rst_n low during pixel 50 with in_valid high → wr=0 next cycle, level=256, buffer_select=0.
